// File: rtl/fast_frame_pkg.sv
// Shared types for the 250 MHz frame delimiter: FSM states and the emitted beat.
package fast_frame_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } delimState_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              sof;
    logic              eof;
    logic              err;
  } frame_beat_t;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fast_frame_delimiter.sv
// Delimits an unmarked byte stream into frames by idle gaps, holding one byte so
// the last byte of a frame can carry EOF; enforces MAX_LEN and keeps statistics.
module fast_frame_delimiter
  import fast_frame_pkg::*;
#(
  parameter int GAP_CYCLES = 8,
  parameter int MAX_LEN    = 1522,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic                 enIn,
  input  logic [BYTE_W-1:0]    dataIn,
  input  logic                 dataValidIn,
  output logic [BYTE_W-1:0]    dataOut,
  output logic                 dataValidOut,
  output logic                 sofOut,
  output logic                 eofOut,
  output logic                 errOut,
  output logic                 busyOut,
  output logic [CNT_WIDTH-1:0] frameCntOut,
  output logic [CNT_WIDTH-1:0] truncCntOut,
  output logic [CNT_WIDTH-1:0] dropCntOut
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [15:0]      MAX_LEN_C = 16'(MAX_LEN);

  delimState_t       r_state,     w_state_nxt;
  logic [BYTE_W-1:0] r_hold,      w_hold_nxt;
  logic              r_sof_pend,  w_sof_pend_nxt;
  logic [15:0]       r_byte_cnt,  w_byte_cnt_nxt;
  logic [GAP_W-1:0]  r_gap_cnt,   w_gap_cnt_nxt;
  frame_beat_t       r_beat,      w_beat_nxt;
  logic              r_beat_vld,  w_beat_vld_nxt;
  logic              r_busy;
  logic              w_inc_frame, w_inc_trunc, w_inc_drop;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_sof_pend <= 1'b0;
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_beat     <= '0;
      r_beat_vld <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_sof_pend <= w_sof_pend_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_beat     <= w_beat_nxt;
      r_beat_vld <= w_beat_vld_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_sof_pend_nxt = r_sof_pend;
    w_byte_cnt_nxt = r_byte_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_beat_nxt     = '0;
    w_beat_vld_nxt = 1'b0;
    w_inc_frame    = 1'b0;
    w_inc_trunc    = 1'b0;
    w_inc_drop     = 1'b0;

    case (r_state)
      IDLE: begin
        if (dataValidIn) begin
          w_gap_cnt_nxt = '0;
          if (enIn) begin
            w_hold_nxt     = dataIn;
            w_sof_pend_nxt = 1'b1;
            w_byte_cnt_nxt = 16'd1;
            w_state_nxt    = ACTIVE;
          end else begin
            w_inc_drop  = 1'b1;
            w_state_nxt = DROP;
          end
        end
      end

      ACTIVE: begin
        // A byte arriving on the cycle the gap would expire keeps the frame open.
        if (dataValidIn) begin
          w_gap_cnt_nxt  = '0;
          w_beat_vld_nxt = 1'b1;
          w_beat_nxt     = '{data: r_hold, sof: r_sof_pend, eof: 1'b0, err: 1'b0};
          if (r_byte_cnt < MAX_LEN_C) begin
            w_hold_nxt     = dataIn;
            w_sof_pend_nxt = 1'b0;
            w_byte_cnt_nxt = r_byte_cnt + 16'd1;
          end else begin
            w_beat_nxt.eof = 1'b1;
            w_beat_nxt.err = 1'b1;
            w_inc_trunc    = 1'b1;
            w_state_nxt    = DROP;
          end
        end else if (r_gap_cnt == GAP_LAST) begin
          w_gap_cnt_nxt  = '0;
          w_beat_vld_nxt = 1'b1;
          w_beat_nxt     = '{data: r_hold, sof: r_sof_pend, eof: 1'b1, err: 1'b0};
          w_inc_frame    = 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end

      DROP: begin
        if (dataValidIn) begin
          w_gap_cnt_nxt = '0;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .i_clk   (clkIn),
    .i_rst_n (rstNIn),
    .i_inc   (w_inc_frame),
    .i_clear (1'b0),
    .o_cnt   (frameCntOut)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_trunc_cnt (
    .i_clk   (clkIn),
    .i_rst_n (rstNIn),
    .i_inc   (w_inc_trunc),
    .i_clear (1'b0),
    .o_cnt   (truncCntOut)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .i_clk   (clkIn),
    .i_rst_n (rstNIn),
    .i_inc   (w_inc_drop),
    .i_clear (1'b0),
    .o_cnt   (dropCntOut)
  );

  assign dataOut      = r_beat.data;
  assign sofOut       = r_beat.sof;
  assign eofOut       = r_beat.eof;
  assign errOut       = r_beat.err;
  assign dataValidOut = r_beat_vld;
  assign busyOut      = r_busy;

endmodule

// File: tb/tb_fast_frame_delimiter.sv
// Directed bench: main instance uses GAP_CYCLES=8, MAX_LEN=4; a second small
// instance (GAP_CYCLES=4, CNT_WIDTH=3) exercises counter saturation quickly.
module tb_fast_frame_delimiter;

  logic       clkIn;
  logic       rstNIn;
  logic       enIn;
  logic [7:0] dataIn;
  logic       dataValidIn;
  logic [7:0] dataOut;
  logic       dataValidOut, sofOut, eofOut, errOut, busyOut;
  logic [15:0] frameCntOut, truncCntOut, dropCntOut;

  logic       s_en;
  logic [7:0] s_dataIn;
  logic       s_validIn;
  logic [7:0] s_dataOut;
  logic       s_validOut, s_sof, s_eof, s_err, s_busy;
  logic [2:0] s_frame, s_trunc, s_drop;

  int n_assert = 0;
  int n_fail   = 0;

  fast_frame_delimiter #(.GAP_CYCLES(8), .MAX_LEN(4), .CNT_WIDTH(16)) dut (
    .clkIn(clkIn), .rstNIn(rstNIn), .enIn(enIn), .dataIn(dataIn),
    .dataValidIn(dataValidIn), .dataOut(dataOut), .dataValidOut(dataValidOut),
    .sofOut(sofOut), .eofOut(eofOut), .errOut(errOut), .busyOut(busyOut),
    .frameCntOut(frameCntOut), .truncCntOut(truncCntOut), .dropCntOut(dropCntOut)
  );

  fast_frame_delimiter #(.GAP_CYCLES(4), .MAX_LEN(1522), .CNT_WIDTH(3)) dut_sat (
    .clkIn(clkIn), .rstNIn(rstNIn), .enIn(s_en), .dataIn(s_dataIn),
    .dataValidIn(s_validIn), .dataOut(s_dataOut), .dataValidOut(s_validOut),
    .sofOut(s_sof), .eofOut(s_eof), .errOut(s_err), .busyOut(s_busy),
    .frameCntOut(s_frame), .truncCntOut(s_trunc), .dropCntOut(s_drop)
  );

  // Clock / reset
  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic s,
                          input logic e, input logic er);
    chk(tag, 32'({dataValidOut, dataOut, sofOut, eofOut, errOut}),
        32'({1'b1, d, s, e, er}));
  endtask

  task automatic chk_none(input string tag);
    chk(tag, 32'(dataValidOut), 32'd0);
  endtask

  // Drivers: inputs change 1 time unit after the edge, outputs sampled there too
  task automatic cyc(input logic v, input logic [7:0] d);
    dataValidIn = v;
    dataIn      = d;
    @(posedge clkIn);
    #1;
  endtask

  task automatic idle_none(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 8'h00);
      chk_none(tag);
    end
  endtask

  task automatic s_cyc(input logic v, input logic [7:0] d);
    s_validIn = v;
    s_dataIn  = d;
    @(posedge clkIn);
    #1;
  endtask

  initial begin
    rstNIn = 1'b0; enIn = 1'b1; dataIn = '0; dataValidIn = 1'b0;
    s_en = 1'b1; s_dataIn = '0; s_validIn = 1'b0;
    #3;
    chk("rst_outputs", 32'({dataValidOut, dataOut, sofOut, eofOut, errOut, busyOut}), 32'd0);
    chk("rst_counters", 32'({frameCntOut, truncCntOut}), 32'd0);
    chk("rst_drop", 32'(dropCntOut), 32'd0);
    @(negedge clkIn);
    rstNIn = 1'b1;
    @(posedge clkIn);
    #1;

    // Four-byte frame, bytes every 2 cycles
    cyc(1'b1, 8'hA1); chk_none("t1_first"); chk("t1_busy", 32'(busyOut), 32'd1);
    cyc(1'b0, 8'h00); chk_none("t1_idle");
    cyc(1'b1, 8'hA2); chk_beat("t1_a1", 8'hA1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00); chk_none("t1_pulse");
    cyc(1'b1, 8'hA3); chk_beat("t1_a2", 8'hA2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hA4); chk_beat("t1_a3", 8'hA3, 1'b0, 1'b0, 1'b0);
    idle_none(7, "t1_gap");
    cyc(1'b0, 8'h00); chk_beat("t1_a4_eof", 8'hA4, 1'b0, 1'b1, 1'b0);
    chk("t1_frame_cnt", 32'(frameCntOut), 32'd1);
    chk("t1_busy_end", 32'(busyOut), 32'd0);
    idle_none(3, "t1_tail");

    // Single-byte frame
    cyc(1'b1, 8'h5C); chk_none("t2_first");
    idle_none(7, "t2_gap");
    cyc(1'b0, 8'h00); chk_beat("t2_single", 8'h5C, 1'b1, 1'b1, 1'b0);
    chk("t2_frame_cnt", 32'(frameCntOut), 32'd2);

    // Truncation at MAX_LEN=4 with 7 bytes offered
    cyc(1'b1, 8'hB1); chk_none("t3_first");
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hB2); chk_beat("t3_b1", 8'hB1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hB3); chk_beat("t3_b2", 8'hB2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hB4); chk_beat("t3_b3", 8'hB3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hB5); chk_beat("t3_b4_trunc", 8'hB4, 1'b0, 1'b1, 1'b1);
    chk("t3_trunc_cnt", 32'(truncCntOut), 32'd1);
    chk("t3_busy_drop", 32'(busyOut), 32'd1);
    cyc(1'b0, 8'h00); chk_none("t3_sup_idle");
    cyc(1'b1, 8'hB6); chk_none("t3_b6_sup");
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hB7); chk_none("t3_b7_sup");
    idle_none(7, "t3_drop_gap");
    chk("t3_busy_pre", 32'(busyOut), 32'd1);
    cyc(1'b0, 8'h00); chk("t3_busy_end", 32'(busyOut), 32'd0);
    chk("t3_frame_cnt", 32'(frameCntOut), 32'd2);

    // Disabled at first byte; enable raised mid-frame has no effect
    enIn = 1'b0;
    cyc(1'b1, 8'hC1); chk_none("t4_c1");
    chk("t4_drop_cnt", 32'(dropCntOut), 32'd1);
    chk("t4_busy", 32'(busyOut), 32'd1);
    enIn = 1'b1;
    cyc(1'b0, 8'h00); chk_none("t4_idle");
    cyc(1'b1, 8'hC2); chk_none("t4_c2");
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hC3); chk_none("t4_c3");
    idle_none(7, "t4_gap");
    cyc(1'b0, 8'h00); chk_none("t4_no_eof");
    chk("t4_busy_end", 32'(busyOut), 32'd0);
    chk("t4_drop_hold", 32'(dropCntOut), 32'd1);
    cyc(1'b1, 8'hD1); chk_none("t4_d1");
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hD2); chk_beat("t4_d1_out", 8'hD1, 1'b1, 1'b0, 1'b0);
    idle_none(7, "t4_d_gap");
    cyc(1'b0, 8'h00); chk_beat("t4_d2_eof", 8'hD2, 1'b0, 1'b1, 1'b0);
    chk("t4_frame_cnt", 32'(frameCntOut), 32'd3);

    // Gap boundary: 7 idle cycles keep the frame, 8 idle cycles split it
    cyc(1'b1, 8'hE1);
    idle_none(7, "t5_e_gap");
    cyc(1'b1, 8'hE2); chk_beat("t5_e1_cont", 8'hE1, 1'b1, 1'b0, 1'b0);
    idle_none(7, "t5_e2_gap");
    cyc(1'b0, 8'h00); chk_beat("t5_e2_eof", 8'hE2, 1'b0, 1'b1, 1'b0);
    chk("t5_frame_cnt_a", 32'(frameCntOut), 32'd4);
    cyc(1'b1, 8'hF1);
    idle_none(7, "t5_f_gap");
    cyc(1'b0, 8'h00); chk_beat("t5_f1_split", 8'hF1, 1'b1, 1'b1, 1'b0);
    chk("t5_busy_split", 32'(busyOut), 32'd0);
    cyc(1'b1, 8'hF2); chk_none("t5_f2_in");
    chk("t5_busy_f2", 32'(busyOut), 32'd1);
    idle_none(7, "t5_f2_gap");
    cyc(1'b0, 8'h00); chk_beat("t5_f2_sof", 8'hF2, 1'b1, 1'b1, 1'b0);
    chk("t5_frame_cnt_b", 32'(frameCntOut), 32'd6);

    // Asynchronous reset mid-frame
    cyc(1'b1, 8'h91);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h92); chk_beat("t6_pre", 8'h91, 1'b1, 1'b0, 1'b0);
    #1;
    rstNIn = 1'b0;
    #1;
    chk("t6_async_out", 32'({dataValidOut, dataOut, sofOut, eofOut, errOut, busyOut}), 32'd0);
    chk("t6_async_cnt", 32'({frameCntOut, truncCntOut}), 32'd0);
    chk("t6_async_drop", 32'(dropCntOut), 32'd0);
    dataValidIn = 1'b0;
    @(negedge clkIn);
    rstNIn = 1'b1;
    @(posedge clkIn);
    #1;
    idle_none(10, "t6_no_eof");
    cyc(1'b1, 8'h71); chk_none("t6_h1");
    cyc(1'b1, 8'h72); chk_beat("t6_h1_sof", 8'h71, 1'b1, 1'b0, 1'b0);
    idle_none(7, "t6_h_gap");
    cyc(1'b0, 8'h00); chk_beat("t6_h2_eof", 8'h72, 1'b0, 1'b1, 1'b0);
    chk("t6_frame_cnt", 32'(frameCntOut), 32'd1);

    // Saturation on the 3-bit instance: nine single-byte frames, count sticks at 7
    for (int i = 0; i < 9; i++) begin
      s_cyc(1'b1, 8'(8'h30 + i));
      repeat (3) s_cyc(1'b0, 8'h00);
      s_cyc(1'b0, 8'h00);
      chk("sat_beat", 32'({s_validOut, s_dataOut, s_sof, s_eof, s_err}),
          32'({1'b1, 8'(8'h30 + i), 1'b1, 1'b1, 1'b0}));
      chk("sat_frame_cnt", 32'(s_frame), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end
    chk("sat_other_cnts", 32'({s_trunc, s_drop, s_busy}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fast_frame_delimiter.md
Name: fast_frame_delimiter

Overview:
Sits in the 250 MHz domain directly after the 125→250 MHz byte CDC, whose output stream carries no frame markers. It delimits frames by inter-byte idle gaps, holds one byte so the last byte can carry EOF, and enforces a maximum frame length. It gates frame admission with an enable and keeps saturating frame, truncation and drop statistics for the downstream book-building parser.

Parameters:
GAP_CYCLES, 8, consecutive idle clkIn cycles that end a frame; legal range 4..255 (CDC delivers bytes every 2–3 cycles).
MAX_LEN, 1522, maximum bytes per frame; legal range 2..65535.
CNT_WIDTH, 16, width of each statistics counter.

Ports:
clkIn  input  1  250 MHz clock
rstNIn  input  1  asynchronous active-low reset
enIn  input  1  frame admission enable, sampled only on a frame's first byte
dataIn  input  8  byte from CDC
dataValidIn  input  1  dataIn valid, one byte per asserted cycle
dataOut  output  8  delimited byte
dataValidOut  output  1  dataOut valid
sofOut  output  1  first byte of frame, qualified by dataValidOut
eofOut  output  1  last byte of frame, qualified by dataValidOut
errOut  output  1  frame truncated at MAX_LEN, valid with eofOut
busyOut  output  1  state != IDLE
frameCntOut  output  CNT_WIDTH  frames ended by gap (good frames)
truncCntOut  output  CNT_WIDTH  frames truncated
dropCntOut  output  CNT_WIDTH  frames rejected because enIn=0

Behaviour:
- Reset, asynchronous on rstNIn=0: state IDLE; all outputs and counters 0; holding register, byteCnt, gapCnt and sofPending cleared. A reset during a frame discards the held byte and emits no EOF.
- All outputs are registered. An event at edge N is visible in the cycle after edge N. dataValidOut is a one-cycle pulse per byte.
- IDLE, dataValidIn=1:
  - If enIn=1: load holdReg=dataIn; set sofPending=1, byteCnt=1, gapCnt=0; go to ACTIVE.
  - If enIn=0: increment dropCnt; set gapCnt=0; go to DROP.
- ACTIVE, dataValidIn=1 and byteCnt<MAX_LEN: emit holdReg with sofOut=sofPending and eofOut=0; load holdReg=dataIn; clear sofPending; increment byteCnt; clear gapCnt.
- ACTIVE, dataValidIn=1 and byteCnt==MAX_LEN: emit holdReg with eofOut=1, errOut=1 and sofOut=sofPending; discard dataIn; increment truncCnt; clear gapCnt; go to DROP.
- ACTIVE, dataValidIn=0: increment gapCnt. When gapCnt reaches GAP_CYCLES-1, on the GAP_CYCLES-th idle cycle: emit holdReg with eofOut=1, errOut=0 and sofOut=sofPending; increment frameCnt; go to IDLE.
- DROP: a valid byte clears gapCnt. GAP_CYCLES consecutive idle cycles return the block to IDLE.
- A valid byte arriving on the same cycle the gap would expire wins: the gap counter resets and the frame continues.
- A single-byte frame emits one beat with sofOut=1 and eofOut=1.
- enIn changes mid-frame have no effect; enIn is re-sampled only at the next frame start.
- Latency: a byte is emitted on the edge the following byte arrives, visible 1 cycle later. The last byte is emitted GAP_CYCLES cycles after its arrival, plus 1 cycle.
- Arithmetic: byteCnt is 16 bits. gapCnt is $clog2(GAP_CYCLES) bits. Statistics counters saturate at all-ones and never wrap.
- No backpressure: the downstream block must accept one byte per cycle.

Decomposition:
- Package fast_frame_pkg:
  - typedef enum logic [1:0] {IDLE, ACTIVE, DROP} delimState_t.
  - localparam BYTE_W=8.
  - A struct packing data, sof, eof and err for downstream use.
- Sub-module sat_counter, parameterised by width, with inc and clear inputs and an async active-low reset. It is instantiated three times, once per statistics counter.

Test Plan:
- Reset, enIn=1; send 4 bytes 0xA1..0xA4 every 2 cycles, then idle 20 cycles → 4 output beats. Only 0xA1 has sofOut=1; 0xA4 has eofOut=1, appearing 9 cycles after its input. frameCntOut=1; busyOut returns to 0.
- Single byte 0x5C, then idle → one beat with sofOut=eofOut=1 and errOut=0; frameCntOut increments by 1.
- MAX_LEN=4; send 7 bytes back-to-back every 2 cycles → 4 beats, the 4th with eofOut=errOut=1. Bytes 5..7 are suppressed; truncCntOut=1. After GAP_CYCLES idle cycles busyOut=0.
- enIn=0 at the first byte of a 3-byte frame, then enIn=1 mid-frame → no output beats, dropCntOut=1. The next frame is accepted normally.
- Gap boundary, GAP_CYCLES=8: bytes spaced exactly 8 cycles apart (7 idle cycles) stay in one frame. A spacing of 9 cycles (8 idle cycles) splits into two frames, with eofOut on the earlier byte and sofOut on the next.
- Assert rstNIn=0 asynchronously mid-frame → all outputs 0 immediately; no eofOut is emitted. After release, a new frame starts with sofOut=1. Also force frameCntOut to saturate at 0xFFFF with CNT_WIDTH=16 → it holds 0xFFFF.
